// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
//   Two WIDTH-bit operands are accepted over a valid/ready handshake, then
//   pushed LSB-first through one shared 1-bit full adder. The full adder is two
//   half_adder instances plus a carry flop. The WIDTH-bit sum and the carry out
//   are returned over a second valid/ready handshake. This trades latency for area.
//   WIDTH must be in the range 2..64.
// Optional feature: define SERIAL_ADD_SUB_EN to add a Sub input.
//   With Sub=1 the block computes A-B mod 2^WIDTH, using ~B with carry-in 1.
//   Carry_Out=1 then means there was no borrow (A >= B unsigned).
//   Without the macro the block only adds, with carry-in 0.

// Half adder: one stage of the shared full adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             Sub,
`endif
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry_Out,
  output logic             Busy,
  output logic [1:0]       dbg_state
);

  // The bit counter must be able to hold WIDTH-1.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Handshake rules, for both ports:
  //   - A transfer happens on a rising edge where valid and ready are both high.
  //   - Ready and valid come straight from the state register, so there are no
  //     combinational paths from input to output.
  //   - In_Ready is high only in IDLE, and Out_Valid only in DONE.
  //   - Outside those states, the inputs on that side are ignored.
  //   - The producer may hold valid high across cycles. The next accept can
  //     happen at the earliest one edge after the result is taken.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             carry_out_q;
  logic [CNT_W-1:0] cnt_q;

  // Control strobes decoded from the FSM.
  logic accept;
  logic step;
  logic last;
  logic take;

  // Full-adder datapath signals.
  logic ha1_sum, ha1_carry;
  logic ha2_sum, ha2_carry;
  logic bit_out;
  logic carry_next;

  // Operand loads that depend on the add/subtract option.
  logic [WIDTH-1:0] b_load;
  logic             cin_load;

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is A + ~B + 1: invert B on load and preset the carry.
  assign b_load   = Sub ? ~B : B;
  assign cin_load = Sub;
`else
  assign b_load   = B;
  assign cin_load = 1'b0;
`endif

  // First half adder combines the two operand bits.
  half_adder ha1 (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .sum   (ha1_sum),
    .carry (ha1_carry)
  );

  // Second half adder folds in the running carry.
  half_adder ha2 (
    .a     (ha1_sum),
    .b     (carry_q),
    .sum   (ha2_sum),
    .carry (ha2_carry)
  );

  assign bit_out    = ha2_sum;
  assign carry_next = ha1_carry | ha2_carry;

  // State register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (In_Valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (Out_Ready) begin
          take    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers.
  //   - Accept: load the shift registers and the carry-in.
  //   - Each RUN edge: retire one bit and shift the sum in from the top.
  //   - Sum and Carry_Out are left untouched outside RUN, so the last result
  //     stays visible until the next operation starts shifting.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      cnt_q       <= '0;
    end else if (accept) begin
      a_sh_q  <= A;
      b_sh_q  <= b_load;
      carry_q <= cin_load;
      cnt_q   <= '0;
    end else if (step) begin
      a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
      sum_q   <= {bit_out, sum_q[WIDTH-1:1]};
      carry_q <= carry_next;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last) begin
        carry_out_q <= carry_next;
      end
    end
  end

  // Internal consistency checks; these have no effect in synthesis.
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      assert (!(take && accept))
        else $error("serial_add_ctrl: accept and take in the same cycle");
      assert (state_q != RUN || cnt_q <= CNT_W'(WIDTH - 1))
        else $error("serial_add_ctrl: bit counter overran WIDTH-1");
    end
  end

  assign In_Ready  = (state_q == IDLE);
  assign Out_Valid = (state_q == DONE);
  assign Busy      = (state_q == RUN) || (state_q == DONE);
  assign Sum       = sum_q;
  assign Carry_Out = carry_out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl with WIDTH=8.
// Build with +define+SERIAL_ADD_SUB_EN to also cover subtraction.
module tb_serial_add_ctrl;

  localparam int W = 8;
  localparam int TIMEOUT = 100;

  logic         Clk;
  logic         Rst_n;
  logic         In_Valid;
  logic         In_Ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
`ifdef SERIAL_ADD_SUB_EN
  logic         Sub;
`endif
  logic         Out_Valid;
  logic         Out_Ready;
  logic [W-1:0] Sum;
  logic         Carry_Out;
  logic         Busy;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .A         (A),
    .B         (B),
`ifdef SERIAL_ADD_SUB_EN
    .Sub       (Sub),
`endif
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Sum       (Sum),
    .Carry_Out (Carry_Out),
    .Busy      (Busy),
    .dbg_state (dbg_state)
  );

  // Clock generation
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Driver: advance one clock and settle 1ns past the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Driver: present one operand pair for exactly one accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    A = a;
    B = b;
    In_Valid = 1'b1;
    tick();
    In_Valid = 1'b0;
  endtask

  // Driver: count cycles from the accept edge until Out_Valid is high (bounded).
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!Out_Valid && cyc < TIMEOUT) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    In_Valid = 1'b0;
    Out_Ready = 1'b1;
    A = '0;
    B = '0;
`ifdef SERIAL_ADD_SUB_EN
    Sub = 1'b0;
`endif
    tick();
    tick();
    Rst_n = 1'b1;
    tick();
    checks++;
    if (In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", In_Ready);
    end
    checks++;
    if (Out_Valid !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_busy: got out_valid=%b busy=%b expected 0 0", Out_Valid, Busy);
    end
    checks++;
    if (Sum !== 8'h00 || Carry_Out !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: got sum=%h co=%b expected 00 0", Sum, Carry_Out);
    end
  endtask

  task automatic test_basic_add();
    int cyc;
    Out_Ready = 1'b1;
    send(8'h15, 8'h27);
    checks++;
    if (In_Ready !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL add_busy_after_accept: got in_ready=%b busy=%b expected 0 1", In_Ready, Busy);
    end
    wait_result(cyc);
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("FAIL add_latency: got %0d cycles expected 8", cyc);
    end
    checks++;
    if (Sum !== 8'h3C || Carry_Out !== 1'b0) begin
      errors++;
      $display("FAIL add_result: got sum=%h co=%b expected 3c 0", Sum, Carry_Out);
    end
    tick();
    checks++;
    if (Out_Valid !== 1'b0 || In_Ready !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL add_back_to_idle: got out_valid=%b in_ready=%b busy=%b expected 0 1 0",
               Out_Valid, In_Ready, Busy);
    end
    checks++;
    if (Sum !== 8'h3C) begin
      errors++;
      $display("FAIL add_sum_held_in_idle: got %h expected 3c", Sum);
    end
  endtask

  task automatic test_reset_mid_run();
    send(8'hAA, 8'h11);
    tick();
    tick();
    tick();
    Rst_n = 1'b0;
    tick();
    tick();
    Rst_n = 1'b1;
    tick();
    checks++;
    if (In_Ready !== 1'b1 || Out_Valid !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_ctrl: got in_ready=%b out_valid=%b busy=%b expected 1 0 0",
               In_Ready, Out_Valid, Busy);
    end
    checks++;
    if (Sum !== 8'h00 || Carry_Out !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_result: got sum=%h co=%b expected 00 0", Sum, Carry_Out);
    end
  endtask

  task automatic test_overflow();
    int cyc;
    Out_Ready = 1'b1;
    send(8'hFF, 8'h01);
    wait_result(cyc);
    checks++;
    if (cyc !== 8 || Sum !== 8'h00 || Carry_Out !== 1'b1) begin
      errors++;
      $display("FAIL ovf_ff_01: got cyc=%0d sum=%h co=%b expected 8 00 1", cyc, Sum, Carry_Out);
    end
    tick();
    send(8'hFF, 8'hFF);
    wait_result(cyc);
    checks++;
    if (cyc !== 8 || Sum !== 8'hFE || Carry_Out !== 1'b1) begin
      errors++;
      $display("FAIL ovf_ff_ff: got cyc=%0d sum=%h co=%b expected 8 fe 1", cyc, Sum, Carry_Out);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int cyc;
    Out_Ready = 1'b0;
    send(8'h5A, 8'h33);
    tick();
    // Pulse a competing request while RUN is in progress.
    A = 8'hFF;
    B = 8'hFF;
    In_Valid = 1'b1;
    checks++;
    if (In_Ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_in_ready_run: got %b expected 0", In_Ready);
    end
    tick();
    In_Valid = 1'b0;
    wait_result(cyc);
    checks++;
    if (cyc !== 6) begin
      errors++;
      $display("FAIL bp_latency: got %0d remaining cycles expected 6", cyc);
    end
    for (int i = 0; i < 5; i++) begin
      A = 8'h01;
      B = 8'h02;
      In_Valid = 1'b1;
      tick();
      checks++;
      if (Out_Valid !== 1'b1 || In_Ready !== 1'b0 || Sum !== 8'h8D || Carry_Out !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got out_valid=%b in_ready=%b sum=%h co=%b expected 1 0 8d 0",
                 i, Out_Valid, In_Ready, Sum, Carry_Out);
      end
    end
    In_Valid = 1'b0;
    Out_Ready = 1'b1;
    tick();
    checks++;
    if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0 1", Out_Valid, In_Ready);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    Out_Ready = 1'b1;
    A = 8'h12;
    B = 8'h34;
    In_Valid = 1'b1;
    tick();
    // Second pair waits, held valid, while the first runs.
    A = 8'h80;
    B = 8'h90;
    wait_result(cyc);
    checks++;
    if (cyc !== 8 || Sum !== 8'h46 || Carry_Out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got cyc=%0d sum=%h co=%b expected 8 46 0", cyc, Sum, Carry_Out);
    end
    tick();
    checks++;
    if (In_Ready !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: got in_ready=%b busy=%b expected 1 0", In_Ready, Busy);
    end
    tick();
    In_Valid = 1'b0;
    checks++;
    if (In_Ready !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_accept: got in_ready=%b busy=%b expected 0 1", In_Ready, Busy);
    end
    wait_result(cyc);
    checks++;
    if (cyc !== 8 || Sum !== 8'h10 || Carry_Out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got cyc=%0d sum=%h co=%b expected 8 10 1", cyc, Sum, Carry_Out);
    end
    tick();
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_subtract();
    int cyc;
    Out_Ready = 1'b1;
    Sub = 1'b1;
    send(8'h10, 8'h03);
    Sub = 1'b0;
    wait_result(cyc);
    checks++;
    if (cyc !== 8 || Sum !== 8'h0D || Carry_Out !== 1'b1) begin
      errors++;
      $display("FAIL sub_10_03: got cyc=%0d sum=%h co=%b expected 8 0d 1", cyc, Sum, Carry_Out);
    end
    tick();
    Sub = 1'b1;
    send(8'h03, 8'h10);
    Sub = 1'b0;
    wait_result(cyc);
    checks++;
    if (cyc !== 8 || Sum !== 8'hF3 || Carry_Out !== 1'b0) begin
      errors++;
      $display("FAIL sub_03_10: got cyc=%0d sum=%h co=%b expected 8 f3 0", cyc, Sum, Carry_Out);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_add();
    test_reset_mid_run();
    test_overflow();
    test_backpressure();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_subtract();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
